// File: rtl/param_ring_counter_if.sv
// Bundled control and status signals for param_ring_counter.
// Protocol: there is no handshake. Every control input is sampled on each
// rising clock edge, and its effect shows on the registered outputs after
// that edge. The master drives the controls; the slave (counter) drives
// the code, position and pulse outputs.
interface param_ring_counter_if #(
  parameter int N = 4
);
  localparam int PW = $clog2(2 * N);

  logic          en;
  logic          dir;
  logic          mode;
  logic          load;
  logic [PW-1:0] load_pos;
  logic [N-1:0]  y;
  logic [PW-1:0] pos;
  logic          wrap;
  logic          err;

  modport master (
    output en, dir, mode, load, load_pos,
    input  y, pos, wrap, err
  );

  modport slave (
    input  en, dir, mode, load, load_pos,
    output y, pos, wrap, err
  );
endinterface

// File: rtl/param_ring_counter.sv
// N-position sequencer producing a one-hot ring code (N states) or a
// Johnson code (2N states). Supports run-time mode select, enable,
// up/down stepping, synchronous load and wrap/error pulses.
// All outputs are registered.
module param_ring_counter #(
  parameter int N = 4
) (
  input logic                 clk,
  input logic                 rst,
  param_ring_counter_if.slave bus
);
  localparam int PW = $clog2(2 * N);
  localparam logic [PW-1:0] LAST_RING = PW'(N - 1);
  localparam logic [PW-1:0] LAST_JOHN = PW'(2 * N - 1);

  logic [PW-1:0] pos_q, pos_d;
  logic          mode_q, mode_d;
  logic [N-1:0]  y_q, y_d;
  logic          wrap_q, wrap_d;
  logic          err_q, err_d;
  logic [PW-1:0] last_new;
  logic [PW-1:0] last_cur;

  // Code for a position: ring is one-hot at p; Johnson fills ones from the
  // bottom for p < N, then clears them from the bottom for p >= N.
  function automatic logic [N-1:0] encode(input logic [PW-1:0] p, input logic m);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (!m)
        r[i] = (int'(p) == i);
      else if (int'(p) < N)
        r[i] = (i < int'(p));
      else
        r[i] = (i >= int'(p) - N);
    end
    return r;
  endfunction

  // Next state, priority load > mode change > enable.
  always_comb begin
    pos_d    = pos_q;
    mode_d   = mode_q;
    wrap_d   = 1'b0;
    err_d    = 1'b0;
    last_new = bus.mode ? LAST_JOHN : LAST_RING;
    last_cur = mode_q ? LAST_JOHN : LAST_RING;
    if (bus.load) begin
      if (bus.load_pos <= last_new) begin
        pos_d  = bus.load_pos;
        mode_d = bus.mode;
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.mode != mode_q) begin
      pos_d  = '0;
      mode_d = bus.mode;
    end else if (bus.en) begin
      if (!bus.dir) begin
        if (pos_q == last_cur) begin
          pos_d  = '0;
          wrap_d = 1'b1;
        end else begin
          pos_d = pos_q + PW'(1);
        end
      end else begin
        if (pos_q == '0) begin
          pos_d  = last_cur;
          wrap_d = 1'b1;
        end else begin
          pos_d = pos_q - PW'(1);
        end
      end
    end
    y_d = encode(pos_d, mode_d);
  end

  // State and output registers; reset adopts the mode input immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q  <= '0;
      mode_q <= bus.mode;
      y_q    <= encode('0, bus.mode);
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      mode_q <= mode_d;
      y_q    <= y_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign bus.y    = y_q;
  assign bus.pos  = pos_q;
  assign bus.wrap = wrap_q;
  assign bus.err  = err_q;
endmodule

// File: tb/tb_param_ring_counter.sv
// Bench for param_ring_counter: an N=4 and an N=5 instance, each tracked by
// an arithmetic model and compared every cycle, plus directed literal checks.
module tb_param_ring_counter;
  logic clk;
  logic rst4, rst5;
  int   checks = 0;
  int   errors = 0;

  param_ring_counter_if #(.N(4)) if4 ();
  param_ring_counter_if #(.N(5)) if5 ();

  param_ring_counter #(.N(4)) u4 (.clk(clk), .rst(rst4), .bus(if4));
  param_ring_counter #(.N(5)) u5 (.clk(clk), .rst(rst5), .bus(if5));

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  int m4_pos = 0, m5_pos = 0;
  bit m4_mode = 0, m5_mode = 0, m4_wrap = 0, m5_wrap = 0, m4_err = 0, m5_err = 0;
  bit m4_valid = 0, m5_valid = 0;
  logic [31:0] exp_q[$];

  function automatic int model_code(int n, int p, bit m);
    int full;
    full = (1 << n) - 1;
    if (!m) return 1 << p;
    if (p < n) return (1 << p) - 1;
    return (~((1 << (p - n)) - 1)) & full;
  endfunction

  task automatic model_step(input int n, input bit r, e, d, md, ld, input int lp,
                            input int pos_i, input bit mq_i,
                            output int pos_o, output bit mq_o, output bit w_o, output bit e_o);
    int mcur;
    pos_o = pos_i; mq_o = mq_i; w_o = 0; e_o = 0;
    mcur = mq_i ? 2 * n : n;
    if (r) begin
      pos_o = 0; mq_o = md;
    end else if (ld) begin
      if (lp < (md ? 2 * n : n)) begin pos_o = lp; mq_o = md; end
      else e_o = 1;
    end else if (md != mq_i) begin
      pos_o = 0; mq_o = md;
    end else if (e) begin
      if (!d) begin
        pos_o = (pos_i + 1) % mcur;
        w_o   = (pos_i + 1 == mcur);
      end else begin
        pos_o = (pos_i + mcur - 1) % mcur;
        w_o   = (pos_i == 0);
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(4, rst4, if4.en, if4.dir, if4.mode, if4.load, int'(if4.load_pos),
               m4_pos, m4_mode, m4_pos, m4_mode, m4_wrap, m4_err);
    model_step(5, rst5, if5.en, if5.dir, if5.mode, if5.load, int'(if5.load_pos),
               m5_pos, m5_mode, m5_pos, m5_mode, m5_wrap, m5_err);
    if (rst4) m4_valid = 1;
    if (rst5) m5_valid = 1;
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m4_valid) begin
      check("u4_model_y",    int'(if4.y),    model_code(4, m4_pos, m4_mode));
      check("u4_model_pos",  int'(if4.pos),  m4_pos);
      check("u4_model_wrap", int'(if4.wrap), int'(m4_wrap));
      check("u4_model_err",  int'(if4.err),  int'(m4_err));
    end
    if (m5_valid) begin
      check("u5_model_y",    int'(if5.y),    model_code(5, m5_pos, m5_mode));
      check("u5_model_pos",  int'(if5.pos),  m5_pos);
      check("u5_model_wrap", int'(if5.wrap), int'(m5_wrap));
      check("u5_model_err",  int'(if5.err),  int'(m5_err));
    end
  end

  // ---------------- drivers ----------------
  task automatic step4(input bit r, e, d, m, l, input int lp);
    rst4 = r; if4.en = e; if4.dir = d; if4.mode = m; if4.load = l; if4.load_pos = 3'(lp);
    @(negedge clk);
  endtask

  task automatic step5(input bit r, e, d, m, l, input int lp);
    rst5 = r; if5.en = e; if5.dir = d; if5.mode = m; if5.load = l; if5.load_pos = 4'(lp);
    @(negedge clk);
  endtask

  // Literal expectations: pushed as {y, pos, wrap, err} and popped against the DUT.
  task automatic lit4(input string nm, input int y, input int p, input int w, input int e);
    logic [31:0] x;
    exp_q.push_back({8'(y), 8'(p), 8'(w), 8'(e)});
    x = exp_q.pop_front();
    check({nm, "_y"},    int'(if4.y),    int'(x[31:24]));
    check({nm, "_pos"},  int'(if4.pos),  int'(x[23:16]));
    check({nm, "_wrap"}, int'(if4.wrap), int'(x[15:8]));
    check({nm, "_err"},  int'(if4.err),  int'(x[7:0]));
  endtask

  task automatic lit5(input string nm, input int y, input int p, input int w, input int e);
    logic [31:0] x;
    exp_q.push_back({8'(y), 8'(p), 8'(w), 8'(e)});
    x = exp_q.pop_front();
    check({nm, "_y"},    int'(if5.y),    int'(x[31:24]));
    check({nm, "_pos"},  int'(if5.pos),  int'(x[23:16]));
    check({nm, "_wrap"}, int'(if5.wrap), int'(x[15:8]));
    check({nm, "_err"},  int'(if5.err),  int'(x[7:0]));
  endtask

  // ---------------- stimulus ----------------
  int ring_y[4]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int john_y[8]  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
  bit cur4_mode, cur5_mode;

  initial begin
    rst4 = 1; if4.en = 0; if4.dir = 0; if4.mode = 0; if4.load = 0; if4.load_pos = '0;
    rst5 = 1; if5.en = 0; if5.dir = 0; if5.mode = 0; if5.load = 0; if5.load_pos = '0;
    @(negedge clk);

    // Ring count-up from reset, wrap on the return to 0001.
    step4(1, 0, 0, 0, 0, 0); lit4("ring_reset", 4'b0001, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step4(0, 1, 0, 0, 0, 0);
      lit4("ring_up", ring_y[i], (i + 1) % 4, (i == 3) ? 1 : 0, 0);
    end

    // Johnson count-up from reset through all 8 states.
    step4(1, 0, 0, 1, 0, 0); lit4("john_reset", 4'b0000, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step4(0, 1, 0, 1, 0, 0);
      lit4("john_up", john_y[i], (i + 1) % 8, (i == 7) ? 1 : 0, 0);
    end

    // Ring count-down wraps 0 -> 3, then steps normally.
    step4(1, 0, 0, 0, 0, 0);
    step4(0, 1, 1, 0, 0, 0); lit4("ring_down_wrap", 4'b1000, 3, 1, 0);
    step4(0, 1, 1, 0, 0, 0); lit4("ring_down", 4'b0100, 2, 0, 0);
    step4(0, 0, 1, 0, 0, 0); lit4("ring_hold", 4'b0100, 2, 0, 0);

    // Out-of-range ring load holds state; reset beats en and load.
    step4(0, 1, 0, 0, 1, 5); lit4("ring_bad_load", 4'b0100, 2, 0, 1);
    step4(0, 1, 0, 0, 0, 0); lit4("ring_after_err", 4'b1000, 3, 0, 0);
    step4(1, 1, 0, 0, 1, 2); lit4("rst_wins", 4'b0001, 0, 0, 0);

    // Johnson load to the last position never pulses wrap, next up does.
    step4(0, 1, 0, 1, 1, 7); lit4("john_load7", 4'b1000, 7, 0, 0);
    step4(0, 1, 0, 1, 0, 0); lit4("john_wrap", 4'b0000, 0, 1, 0);

    // N=5: out-of-range ring load, Johnson load of 7.
    step5(1, 0, 0, 0, 0, 0); lit5("n5_reset", 5'b00001, 0, 0, 0);
    step5(0, 0, 0, 0, 1, 7); lit5("n5_ring_load7", 5'b00001, 0, 0, 1);
    step5(0, 0, 0, 0, 0, 0); lit5("n5_err_clear", 5'b00001, 0, 0, 0);
    step5(0, 0, 0, 1, 1, 7); lit5("n5_john_load7", 5'b11100, 7, 0, 0);

    // N=5: mode change wins over en; load wins over mode change.
    step5(0, 0, 0, 0, 1, 2); lit5("n5_ring_pos2", 5'b00100, 2, 0, 0);
    step5(0, 1, 0, 1, 0, 0); lit5("n5_mode_chg", 5'b00000, 0, 0, 0);
    step5(0, 0, 0, 0, 1, 2); lit5("n5_ring_pos2b", 5'b00100, 2, 0, 0);
    step5(0, 1, 0, 1, 1, 3); lit5("n5_load_vs_mode", 5'b00111, 3, 0, 0);
    step5(0, 0, 0, 1, 1, 0);
    step5(0, 1, 1, 1, 0, 0); lit5("n5_john_down_wrap", 5'b10000, 9, 1, 0);

    // Randomised traffic on both instances, checked against the model.
    cur4_mode = if4.mode;
    cur5_mode = if5.mode;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) cur4_mode = ~cur4_mode;
      if ($urandom_range(0, 9) == 0) cur5_mode = ~cur5_mode;
      rst4 = ($urandom_range(0, 29) == 0);
      if4.en = 1'($urandom_range(0, 3) != 0); if4.dir = 1'($urandom_range(0, 1));
      if4.mode = cur4_mode; if4.load = ($urandom_range(0, 7) == 0);
      if4.load_pos = 3'($urandom_range(0, 7));
      rst5 = ($urandom_range(0, 29) == 0);
      if5.en = 1'($urandom_range(0, 3) != 0); if5.dir = 1'($urandom_range(0, 1));
      if5.mode = cur5_mode; if5.load = ($urandom_range(0, 7) == 0);
      if5.load_pos = 4'($urandom_range(0, 15));
      @(negedge clk);
    end

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
